lb_burst_reader: RTL

Burst read sequencer that drains an acquisition or accumulation buffer over the local bus into a valid/ready stream. It sits between a readout client (DMA/packetizer) and the bus-side read port of the BRAM controller. It converts one (address, length) command into back-to-back single-word local-bus reads with a fixed read latency. Credit-based flow control ensures the internal FIFO never overflows under downstream backpressure.

---
 rtl/lb_burst_reader.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/lb_burst_reader.sv
// Burst read sequencer: turns one (addr, len) command into single-word local-bus
// reads and streams the responses out through a credit-protected response FIFO.
module lb_burst_reader #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int RD_LATENCY = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  lb_rden,
  output logic [ADDR_WIDTH-1:0] lb_raddr,
  output logic                  lb_rdenlast,
  input  logic [DATA_WIDTH-1:0] lb_rdata,
  input  logic                  lb_rvalid,
  input  logic                  lb_rvalidlast,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // ISSUE | issuing reads while credit allows
  // DRAIN | all reads issued, waiting for the last beat to leave
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]         DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW:0]           DEPTH_W  = (CW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0]         PTR_ONE  = PW'(1);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH:0]    LEN_ONEW = (LEN_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                state_q;
  logic                  cmd_ready_q, lb_rden_q, lb_rdenlast_q, busy_q, done_q, err_q;
  logic                  last_seen_q;
  logic [ADDR_WIDTH-1:0] lb_raddr_q, cur_q;
  logic [LEN_WIDTH-1:0]  rem_q, len_q, rcv_q;
  logic [CW-1:0]         out_q, cnt_q;
  logic [PW-1:0]         wr_q, rd_q;
  logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
  logic                  mem_last_q [FIFO_DEPTH];

  logic                  accept, credit, issue, resp_ok, resp_last, push, pop, fifo_nonempty, head_last;
  logic [ADDR_WIDTH-1:0] iss_addr;
  logic [LEN_WIDTH-1:0]  iss_rem;

  always_comb begin
    accept        = cmd_valid && cmd_ready_q;
    credit        = ({1'b0, out_q} + {1'b0, cnt_q}) < DEPTH_W;
    iss_addr      = accept ? cmd_addr : cur_q;
    iss_rem       = accept ? cmd_len : rem_q;
    // The first read goes out on the accept edge so the strobe appears one cycle later.
    issue         = credit && ((accept && cmd_len != '0) || (state_q == ISSUE));
    resp_ok       = lb_rvalid && (out_q != '0);
    resp_last     = ({1'b0, rcv_q} + LEN_ONEW) == {1'b0, len_q};
    fifo_nonempty = cnt_q != '0;
    head_last     = mem_last_q[rd_q];
    pop           = fifo_nonempty && m_ready;
    push          = resp_ok && ((cnt_q != DEPTH_C) || pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_q] <= lb_rdata;
      mem_last_q[wr_q] <= resp_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b1;
      lb_rden_q     <= 1'b0;
      lb_rdenlast_q <= 1'b0;
      lb_raddr_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      last_seen_q   <= 1'b0;
      cur_q         <= '0;
      rem_q         <= '0;
      len_q         <= '0;
      rcv_q         <= '0;
      out_q         <= '0;
      cnt_q         <= '0;
      wr_q          <= '0;
      rd_q          <= '0;
    end else begin
      lb_rden_q     <= issue;
      lb_rdenlast_q <= issue && (iss_rem == LEN_ONE);
      if (issue) begin
        lb_raddr_q <= iss_addr;
        cur_q      <= iss_addr + ADDR_ONE;
        rem_q      <= iss_rem - LEN_ONE;
      end else if (accept) begin
        cur_q <= cmd_addr;
        rem_q <= cmd_len;
      end

      out_q <= out_q + CW'(issue) - CW'(resp_ok);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      if (push) wr_q <= wr_q + PTR_ONE;
      if (pop)  rd_q <= rd_q + PTR_ONE;

      if (accept) begin
        len_q       <= cmd_len;
        rcv_q       <= '0;
        last_seen_q <= 1'b0;
        err_q       <= 1'b0;
      end else begin
        if (resp_ok) rcv_q <= rcv_q + LEN_ONE;
        if (pop && head_last) last_seen_q <= 1'b1;
      end
      // Error set takes priority over the clear on accept.
      if ((lb_rvalid && out_q == '0) || (resp_ok && (lb_rvalidlast != resp_last)) ||
          (resp_ok && !push))
        err_q <= 1'b1;

      done_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          cmd_ready_q <= 1'b0;
          busy_q      <= 1'b1;
          if (cmd_len == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (issue && cmd_len == LEN_ONE) state_q <= DRAIN;
          else state_q <= ISSUE;
        end
        ISSUE: if (issue && rem_q == LEN_ONE) state_q <= DRAIN;
        DRAIN: if (last_seen_q || (pop && head_last)) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign lb_rden     = lb_rden_q;
  assign lb_raddr    = lb_raddr_q;
  assign lb_rdenlast = lb_rdenlast_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign m_valid     = fifo_nonempty;
  assign m_data      = fifo_nonempty ? mem_data_q[rd_q] : '0;
  assign m_last      = fifo_nonempty && head_last;

endmodule
